// File: rtl/multicycle_control_fsm_pkg.sv
// Shared state encodings, RV32I opcode constants and datapath select codes for the
// multi-cycle core sequencer and the ALU control unit.
package multicycle_control_fsm_pkg;

   typedef enum logic [2:0] {
      ST_IF   = 3'd0,
      ST_ID   = 3'd1,
      ST_EX   = 3'd2,
      ST_MEM  = 3'd3,
      ST_WB   = 3'd4,
      ST_HALT = 3'd5
   } state_e;

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   localparam logic [1:0] M2R_ALUOUT = 2'd0;
   localparam logic [1:0] M2R_MDR    = 2'd1;
   localparam logic [1:0] M2R_PC     = 2'd2;

   localparam logic [1:0] SRCA_PC     = 2'd0;
   localparam logic [1:0] SRCA_RS1    = 2'd1;
   localparam logic [1:0] SRCA_OLD_PC = 2'd2;

   localparam logic [1:0] SRCB_RS2  = 2'd0;
   localparam logic [1:0] SRCB_IMM  = 2'd1;
   localparam logic [1:0] SRCB_FOUR = 2'd2;

   localparam logic [1:0] ALUOP_ADD    = 2'd0;
   localparam logic [1:0] ALUOP_FUNCT  = 2'd1;
   localparam logic [1:0] ALUOP_BRANCH = 2'd2;

   function automatic logic is_known_opcode(input logic [6:0] op);
      logic known;
      case (op)
         OP_ARITH, OP_ARITH_IMM, OP_LOAD, OP_STORE,
         OP_BRANCH, OP_JAL, OP_JALR, OP_ECALL: known = 1'b1;
         default:                              known = 1'b0;
      endcase
      return known;
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_next_state.sv
// Combinational next-state logic for the multi-cycle sequencer; reset handling
// lives with the state register in the top.
module multicycle_next_state
   import multicycle_control_fsm_pkg::*;
(
   input  state_e     state,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       halt_req,
   output state_e     next_state
);

   always_comb begin
      next_state = state;
      case (state)
         ST_IF: begin
            if (mem_ready) next_state = ST_ID;
         end
         ST_ID: begin
            if (opcode == OP_ECALL)           next_state = halt_req ? ST_HALT : ST_IF;
            else if (!is_known_opcode(opcode)) next_state = ST_IF;
            else                               next_state = ST_EX;
         end
         ST_EX: begin
            case (opcode)
               OP_ARITH, OP_ARITH_IMM: next_state = ST_WB;
               OP_LOAD, OP_STORE:      next_state = ST_MEM;
               default:                next_state = ST_IF;
            endcase
         end
         ST_MEM: begin
            // Only a load has a writeback; a store retires on its write acknowledge.
            if (mem_ready) next_state = (opcode == OP_LOAD) ? ST_WB : ST_IF;
         end
         ST_WB:   next_state = ST_IF;
         ST_HALT: next_state = ST_HALT;
         default: next_state = ST_IF;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core: state register plus per-state
// decode of every datapath enable and mux select.
module multicycle_control_fsm
   import multicycle_control_fsm_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   input  logic       bcond,
   input  logic       halt_req,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       pc_enable,
   output logic       pc_source,
   output logic       i_or_d,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       reg_write,
   output logic [1:0] mem_to_reg,
   output logic [1:0] alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op_sel,
   output logic       is_halted
);

   state_e state_q;
   state_e state_d;

   multicycle_next_state u_next_state (
      .state      (state_q),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .halt_req   (halt_req),
      .next_state (state_d)
   );

   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_IF;
      else       state_q <= state_d;
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mdr_write     = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = M2R_ALUOUT;
      alu_src_a     = SRCA_PC;
      alu_src_b     = SRCB_RS2;
      alu_op_sel    = ALUOP_ADD;
      is_halted     = 1'b0;
      // Reset gates every output so an in-flight request or a coincident
      // mem_ready cannot fire a write enable.
      if (!reset) begin
         case (state_q)
            ST_IF: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            ST_ID: begin
               alu_src_a = SRCA_OLD_PC;
               alu_src_b = SRCB_IMM;
            end
            ST_EX: begin
               case (opcode)
                  OP_ARITH: begin
                     alu_src_a  = SRCA_RS1;
                     alu_op_sel = ALUOP_FUNCT;
                  end
                  OP_ARITH_IMM: begin
                     alu_src_a  = SRCA_RS1;
                     alu_src_b  = SRCB_IMM;
                     alu_op_sel = ALUOP_FUNCT;
                  end
                  OP_LOAD, OP_STORE: begin
                     alu_src_a = SRCA_RS1;
                     alu_src_b = SRCB_IMM;
                  end
                  OP_BRANCH: begin
                     alu_src_a     = SRCA_RS1;
                     alu_op_sel    = ALUOP_BRANCH;
                     pc_write_cond = 1'b1;
                     pc_source     = 1'b1;
                  end
                  OP_JAL: begin
                     // Target old_pc+imm was already computed into ALUOut during ID.
                     pc_write   = 1'b1;
                     pc_source  = 1'b1;
                     reg_write  = 1'b1;
                     mem_to_reg = M2R_PC;
                  end
                  OP_JALR: begin
                     alu_src_a  = SRCA_RS1;
                     alu_src_b  = SRCB_IMM;
                     pc_write   = 1'b1;
                     reg_write  = 1'b1;
                     mem_to_reg = M2R_PC;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               i_or_d    = 1'b1;
               mem_read  = (opcode == OP_LOAD);
               mem_write = (opcode == OP_STORE);
               mdr_write = (opcode == OP_LOAD) && mem_ready;
            end
            ST_WB: begin
               reg_write  = 1'b1;
               mem_to_reg = (opcode == OP_LOAD) ? M2R_MDR : M2R_ALUOUT;
            end
            ST_HALT: is_halted = 1'b1;
            default: ;
         endcase
      end
      pc_enable = pc_write | (pc_write_cond & bcond);
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: each instruction is expanded into its expected per-cycle output
// trace from the sequencing rules, then driven cycle by cycle and compared.
module tb_multicycle_control_fsm;

   localparam logic [6:0] T_ARITH  = 7'b0110011;
   localparam logic [6:0] T_ARIMM  = 7'b0010011;
   localparam logic [6:0] T_LOAD   = 7'b0000011;
   localparam logic [6:0] T_STORE  = 7'b0100011;
   localparam logic [6:0] T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JAL    = 7'b1101111;
   localparam logic [6:0] T_JALR   = 7'b1100111;
   localparam logic [6:0] T_ECALL  = 7'b1110011;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_enable;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       mdr_write;
      logic       reg_write;
      logic [1:0] mem_to_reg;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op_sel;
      logic       is_halted;
   } out_t;

   typedef struct packed {
      logic       rst;
      logic       mr;
      logic       bc;
      logic       hr;
      logic [6:0] op;
      out_t       exp;
   } step_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] opcode = '0;
   logic       mem_ready = 1'b0;
   logic       bcond = 1'b0;
   logic       halt_req = 1'b0;
   logic       pc_write, pc_write_cond, pc_enable, pc_source, i_or_d, mem_read, mem_write;
   logic       ir_write, mdr_write, reg_write, is_halted;
   logic [1:0] mem_to_reg, alu_src_a, alu_src_b, alu_op_sel;
   out_t       obs;

   step_t sq[$];
   step_t tmp[$];
   int    n_checks = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   multicycle_control_fsm dut (
      .clk           (clk),
      .reset         (reset),
      .opcode        (opcode),
      .mem_ready     (mem_ready),
      .bcond         (bcond),
      .halt_req      (halt_req),
      .pc_write      (pc_write),
      .pc_write_cond (pc_write_cond),
      .pc_enable     (pc_enable),
      .pc_source     (pc_source),
      .i_or_d        (i_or_d),
      .mem_read      (mem_read),
      .mem_write     (mem_write),
      .ir_write      (ir_write),
      .mdr_write     (mdr_write),
      .reg_write     (reg_write),
      .mem_to_reg    (mem_to_reg),
      .alu_src_a     (alu_src_a),
      .alu_src_b     (alu_src_b),
      .alu_op_sel    (alu_op_sel),
      .is_halted     (is_halted)
   );

   assign obs = {pc_write, pc_write_cond, pc_enable, pc_source, i_or_d, mem_read, mem_write,
                 ir_write, mdr_write, reg_write, mem_to_reg, alu_src_a, alu_src_b,
                 alu_op_sel, is_halted};

   task automatic check_val(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
      n_checks++;
      if (observed !== expected) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic bit is_known(input logic [6:0] op);
      return op inside {T_ARITH, T_ARIMM, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_ECALL};
   endfunction

   task automatic push(input logic rst, input logic mr, input logic bc, input logic hr,
                       input logic [6:0] op, input out_t e);
      step_t s;
      s.rst = rst; s.mr = mr; s.bc = bc; s.hr = hr; s.op = op; s.exp = e;
      tmp.push_back(s);
   endtask

   // Expected trace of one instruction: IF waits, ID, then the opcode's remaining phases.
   task automatic gen_instr(input logic [6:0] op, input int wi, input int wm, input logic bc,
                            input logic hr, input int halt_cycles);
      out_t e;
      bit   ld, st;
      ld = (op == T_LOAD);
      st = (op == T_STORE);
      for (int i = 0; i < wi; i++) begin
         e = '0; e.mem_read = 1; e.alu_src_b = 2;
         push(0, 0, rbit(), rbit(), 7'($urandom), e);
      end
      e = '0; e.mem_read = 1; e.alu_src_b = 2; e.ir_write = 1; e.pc_write = 1; e.pc_enable = 1;
      push(0, 1, rbit(), rbit(), 7'($urandom), e);
      e = '0; e.alu_src_a = 2; e.alu_src_b = 1;
      push(0, rbit(), rbit(), hr, op, e);
      if (op == T_ECALL) begin
         if (hr) begin
            for (int i = 0; i < halt_cycles; i++) begin
               e = '0; e.is_halted = 1;
               push(0, rbit(), rbit(), rbit(), 7'($urandom), e);
            end
         end
         return;
      end
      if (!is_known(op)) return;
      e = '0;
      if (op == T_ARITH)  begin e.alu_src_a = 1; e.alu_op_sel = 1; end
      if (op == T_ARIMM)  begin e.alu_src_a = 1; e.alu_src_b = 1; e.alu_op_sel = 1; end
      if (ld || st)       begin e.alu_src_a = 1; e.alu_src_b = 1; end
      if (op == T_BRANCH) begin
         e.alu_src_a = 1; e.alu_op_sel = 2; e.pc_write_cond = 1; e.pc_source = 1;
         e.pc_enable = bc;
      end
      if (op == T_JAL) begin
         e.pc_write = 1; e.pc_enable = 1; e.pc_source = 1; e.reg_write = 1; e.mem_to_reg = 2;
      end
      if (op == T_JALR) begin
         e.alu_src_a = 1; e.alu_src_b = 1; e.pc_write = 1; e.pc_enable = 1;
         e.reg_write = 1; e.mem_to_reg = 2;
      end
      push(0, rbit(), bc, rbit(), op, e);
      if (ld || st) begin
         for (int i = 0; i <= wm; i++) begin
            e = '0; e.i_or_d = 1; e.mem_read = ld; e.mem_write = st;
            e.mdr_write = ld && (i == wm);
            push(0, (i == wm), rbit(), rbit(), op, e);
         end
      end
      if (ld || op == T_ARITH || op == T_ARIMM) begin
         e = '0; e.reg_write = 1; e.mem_to_reg = ld ? 2'd1 : 2'd0;
         push(0, rbit(), rbit(), rbit(), op, e);
      end
   endtask

   // Moves the pending trace into the run queue, optionally cut short by a reset.
   task automatic commit(input bit abort, input bit then_reset, input logic reset_mr);
      int keep;
      keep = tmp.size();
      if (abort && keep > 0) keep = $urandom_range(0, keep - 1);
      for (int i = 0; i < keep; i++) sq.push_back(tmp[i]);
      tmp.delete();
      if (abort || then_reset) push(1, reset_mr, rbit(), rbit(), 7'($urandom), '0);
      while (tmp.size() > 0) sq.push_back(tmp.pop_front());
   endtask

   function automatic logic [6:0] pick_op();
      logic [6:0] op;
      case ($urandom_range(0, 8))
         0: op = T_ARITH;
         1: op = T_ARIMM;
         2: op = T_LOAD;
         3: op = T_STORE;
         4: op = T_BRANCH;
         5: op = T_JAL;
         6: op = T_JALR;
         7: op = T_ECALL;
         default: begin
            op = 7'($urandom);
            while (is_known(op)) op = 7'($urandom);
         end
      endcase
      return op;
   endfunction

   initial begin
      out_t e;
      logic [6:0] op;
      logic       hr;
      int         hc;

      commit(0, 1, 1);
      commit(0, 1, 0);
      gen_instr(T_ARITH, 0, 0, 0, 0, 0);  commit(0, 0, 0);
      gen_instr(T_LOAD, 0, 3, 0, 0, 0);   commit(0, 0, 0);
      gen_instr(T_BRANCH, 0, 0, 1, 0, 0); commit(0, 0, 0);
      gen_instr(T_BRANCH, 0, 0, 0, 0, 0); commit(0, 0, 0);
      gen_instr(T_JAL, 0, 0, 0, 0, 0);    commit(0, 0, 0);
      gen_instr(T_JALR, 1, 0, 0, 0, 0);   commit(0, 0, 0);
      gen_instr(T_STORE, 2, 1, 0, 0, 0);  commit(0, 0, 0);
      gen_instr(T_ARIMM, 0, 0, 0, 0, 0);  commit(0, 0, 0);
      gen_instr(T_ECALL, 0, 0, 0, 0, 0);  commit(0, 0, 0);
      gen_instr(7'b0110111, 0, 0, 0, 0, 0); commit(0, 0, 0);
      // Reset lands in an IF wait together with mem_ready.
      for (int i = 0; i < 2; i++) begin
         e = '0; e.mem_read = 1; e.alu_src_b = 2;
         push(0, 0, rbit(), rbit(), 7'($urandom), e);
      end
      commit(0, 1, 1);
      gen_instr(T_ARITH, 0, 0, 0, 0, 0);  commit(0, 0, 0);
      gen_instr(T_ECALL, 0, 0, 0, 1, 20); commit(0, 1, 1);

      for (int n = 0; n < 150; n++) begin
         op = pick_op();
         hr = ($urandom_range(0, 9) < 3);
         hc = $urandom_range(1, 5);
         gen_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), rbit(), hr, hc);
         commit($urandom_range(0, 9) == 0, (op == T_ECALL) && hr, rbit());
      end

      foreach (sq[i]) begin
         @(posedge clk);
         #1;
         reset     = sq[i].rst;
         mem_ready = sq[i].mr;
         bcond     = sq[i].bc;
         halt_req  = sq[i].hr;
         opcode    = sq[i].op;
         @(negedge clk);
         check_val($sformatf("cycle%0d_rst%0b_op%b", i, sq[i].rst, sq[i].op),
                   32'(obs), 32'(sq[i].exp));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
